core_run_controller: RTL
========================

Name: core_run_controller

Overview:
- Sequential controller that owns the run lifecycle of the RISC-V core (or NUM_HARTS cores) in simulation and FPGA bring-up.
- Sequences an active-low core reset for a programmable hold time, then runs the cores.
- Tracks per-hart halt requests and counts run cycles.
- Terminates the run on all-harts-halted or on a cycle-limit timeout. This replaces fixed-delay reset and finish timing with parametrised, observable behaviour.

Parameters:
- NUM_HARTS, 1, number of core/hart channels monitored.
- RESET_CYCLES, 1, cycles core_reset is held low after start; legal range ≥1.
- MAX_CYCLES, 20, run-cycle limit before timeout; 0 = no limit.
- CNT_W, 32, width of cycle and performance counters.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  level; sampled in IDLE, DONE and TIMEOUT.
- halt_req  input  NUM_HARTS  per-hart halt indication (ebreak/ecall-exit); single-cycle pulses allowed.
- retire_valid  input  NUM_HARTS  per-hart instruction-retired strobe; used only with the optional feature.
- core_reset  output  1  synchronous active-low reset to the cores.
- core_run  output  1  clock-enable to the cores; high only in RUN.
- halted_mask  output  NUM_HARTS  sticky record of harts that have halted.
- cycle_count  output  CNT_W  run cycles elapsed.
- done  output  1  level; all harts halted.
- timeout  output  1  level; cycle limit hit.
- state  output  2  encoded FSM state: IDLE=0, HOLD=1, RUN=2, END=3.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, core_reset=0, core_run=0.
  - halted_mask=0, cycle_count=0, done=0, timeout=0, hold counter=0.
  - Reset takes effect at that edge from any state, including mid-RUN.
- IDLE: core_reset=0. start==1 at edge k → HOLD at k, hold counter cleared.
- HOLD:
  - core_reset=0; hold counter increments each cycle.
  - After RESET_CYCLES cycles in HOLD → RUN, so core_reset=1 from edge k+RESET_CYCLES.
  - On entry to HOLD: cycle_count, halted_mask, done and timeout are cleared.
- RUN:
  - core_reset=1, core_run=1.
  - cycle_count increments every cycle; its value in the first RUN cycle is 0.
  - halted_mask <= halted_mask | halt_req.
  - start is ignored.
- RUN exit, evaluated on next-mask = halted_mask | halt_req:
  - If next-mask is all ones → END with done=1.
  - Else if MAX_CYCLES≠0 and cycle_count==MAX_CYCLES-1 → END with timeout=1.
  - If both conditions hold in the same cycle, done wins and timeout stays 0.
- END:
  - core_run=0, core_reset=1, so core architectural state is frozen and observable.
  - cycle_count, halted_mask, done and timeout hold their values.
  - start==1 → HOLD, which begins a new run. There is no auto-restart while start stays low.
- Counter overflow: cycle_count saturates at all ones and does not wrap. With MAX_CYCLES=0, a saturated count is the only overflow indication.
- Halt inputs: halt_req bits seen outside RUN are ignored. Duplicate halts on an already-halted hart have no effect.
- done and timeout are mutually exclusive and never high outside END.

Optional Feature:
- Macro: CORE_RUN_CTRL_PERF_EN.
- When defined:
  - Adds output port retired_count, width NUM_HARTS*CNT_W; hart i occupies bits [i*CNT_W +: CNT_W].
  - Each hart's counter increments on retire_valid[i] only while in RUN and only while that hart is not yet halted.
  - Counters saturate, are cleared on reset and on entry to HOLD, and hold in END.
- When undefined:
  - No retired_count port and no perf counters.
  - retire_valid remains a port but is unused.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - state typedef/localparams ST_IDLE, ST_HOLD, ST_RUN, ST_END;
  - the 2-bit state width constant;
  - a saturating-increment function used by the cycle and perf counters.
- One natural sub-module: sat_counter (CNT_W, with clear/enable/saturate). It is instanced once for cycle_count and NUM_HARTS times under CORE_RUN_CTRL_PERF_EN.

Test Plan:
- Reset then start: NUM_HARTS=1, RESET_CYCLES=1, start pulsed at edge 2 → core_reset low through edge 2, high from edge 3; state HOLD→RUN; cycle_count=0 in first RUN cycle.
- Timeout: MAX_CYCLES=20, no halts → timeout=1 and state=END after 20 RUN cycles; cycle_count=19; core_run=0; done=0.
- Multi-hart halt: NUM_HARTS=3, halts pulsed on hart 0 at cycle 3, hart 2 at cycle 5, hart 1 at cycle 8 → halted_mask 001, 101, then done=1 in END with cycle_count=8.
- Simultaneous completion: last halt arrives in the cycle where cycle_count==MAX_CYCLES-1 → done=1, timeout=0.
- Mid-run reset: reset=0 during RUN at cycle 7 → next edge state=IDLE, every output at its reset value; a following start gives a clean rerun with cycle_count restarting at 0.
- Perf, with CORE_RUN_CTRL_PERF_EN: 2 harts, retire_valid every cycle on hart 0 and every other cycle on hart 1, hart 0 halts at cycle 9 → hart 0 count=10 and frozen thereafter, hart 1 continues until its own halt.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared state encoding and saturating increment for the run controller.
//   STATE_W   : width of the encoded FSM state
//   state_t   : ST_IDLE=0, ST_HOLD=1, ST_RUN=2, ST_END=3
//   sat_inc() : increment that sticks at the all-ones value of a w-bit counter (w <= SAT_MAX_W)
package core_ctrl_pkg;

    localparam int STATE_W   = 2;
    localparam int SAT_MAX_W = 64;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_END  = 2'd3
    } state_t;

    // Counters narrower than SAT_MAX_W are zero-extended by the caller; lim is
    // the all-ones value at the caller's width.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v, input int w);
        logic [SAT_MAX_W-1:0] lim;
        lim = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
        return (v >= lim) ? v : v + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/core_run_controller_sat_counter.sv
// sat_counter: CNT_W-bit saturating up-counter with synchronous clear.
//   clock : rising-edge clock
//   reset : synchronous active-low reset (count -> 0)
//   clear : synchronous clear (count -> 0), overrides en
//   en    : increment enable; the count sticks at all ones
//   count : current value
module sat_counter
    import core_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock) begin
        if (!reset || clear)
            count <= '0;
        else if (en)
            count <= CNT_W'(sat_inc(SAT_MAX_W'(count), CNT_W));
    end

endmodule

// File: rtl/core_run_controller.sv
// core_run_controller: run lifecycle controller (reset hold, run, halt/timeout termination).
// Optional build macro CORE_RUN_CTRL_PERF_EN adds per-hart retired-instruction counters.
//   clock, reset   : rising-edge clock, synchronous active-low reset
//   start          : level, begins a run from IDLE or END
//   halt_req       : per-hart halt pulses, honoured only in RUN
//   retire_valid   : per-hart retire strobes (perf counters only)
//   core_reset     : active-low reset to the cores, low in IDLE and HOLD
//   core_run       : core clock-enable, high only in RUN
//   halted_mask    : sticky per-hart halted record
//   cycle_count    : saturating run-cycle counter, 0 in the first RUN cycle
//   done / timeout : END reason, mutually exclusive
//   state          : IDLE=0, HOLD=1, RUN=2, END=3
//   retired_count  : (macro only) hart i at [i*CNT_W +: CNT_W]
module core_run_controller
    import core_ctrl_pkg::*;
#(
    parameter int NUM_HARTS    = 1,
    parameter int RESET_CYCLES = 1,
    parameter int MAX_CYCLES   = 20,
    parameter int CNT_W        = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_HARTS-1:0] halt_req,
    input  logic [NUM_HARTS-1:0] retire_valid,
    output logic                 core_reset,
    output logic                 core_run,
    output logic [NUM_HARTS-1:0] halted_mask,
    output logic [CNT_W-1:0]     cycle_count,
    output logic                 done,
    output logic                 timeout,
    output logic [STATE_W-1:0]   state
`ifdef CORE_RUN_CTRL_PERF_EN
    ,
    output logic [NUM_HARTS*CNT_W-1:0] retired_count
`endif
);

    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    state_t               st;
    logic [HW-1:0]        hold_cnt;
    logic [NUM_HARTS-1:0] next_mask;
    logic                 all_halted;
    logic                 at_limit;
    logic                 in_run;
    logic                 enter_hold;

    assign next_mask  = halted_mask | halt_req;
    assign all_halted = &next_mask;
    assign at_limit   = (MAX_CYCLES != 0) && (cycle_count == CNT_W'(MAX_CYCLES - 1));
    assign in_run     = st == ST_RUN;
    assign enter_hold = start && (st == ST_IDLE || st == ST_END);
    assign state      = st;

    always_ff @(posedge clock) begin
        if (!reset) begin
            st          <= ST_IDLE;
            core_reset  <= 1'b0;
            core_run    <= 1'b0;
            halted_mask <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            case (st)
                ST_IDLE, ST_END: begin
                    if (start) begin
                        st          <= ST_HOLD;
                        core_reset  <= 1'b0;
                        hold_cnt    <= '0;
                        halted_mask <= '0;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HW'(RESET_CYCLES - 1)) begin
                        st         <= ST_RUN;
                        core_reset <= 1'b1;
                        core_run   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    halted_mask <= next_mask;
                    // A completing halt takes priority over the cycle limit.
                    if (all_halted) begin
                        st       <= ST_END;
                        core_run <= 1'b0;
                        done     <= 1'b1;
                    end else if (at_limit) begin
                        st       <= ST_END;
                        core_run <= 1'b0;
                        timeout  <= 1'b1;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    // The count is frozen on the exit edge so END reports the last RUN cycle index.
    sat_counter #(.CNT_W(CNT_W)) u_cycle (
        .clock (clock),
        .reset (reset),
        .clear (enter_hold),
        .en    (in_run && !all_halted && !at_limit),
        .count (cycle_count)
    );

`ifdef CORE_RUN_CTRL_PERF_EN
    // A hart's retire in its halting cycle still counts; it stops once the mask records it.
    for (genvar i = 0; i < NUM_HARTS; i++) begin : g_perf
        sat_counter #(.CNT_W(CNT_W)) u_ret (
            .clock (clock),
            .reset (reset),
            .clear (enter_hold),
            .en    (in_run && retire_valid[i] && !halted_mask[i]),
            .count (retired_count[i*CNT_W +: CNT_W])
        );
    end
`else
    logic unused_retire;
    assign unused_retire = ^retire_valid;
`endif

endmodule
